// File: rtl/char_pkg.sv
// Shared types and constants for the per-player character controller.
// Pure declarations: no logic, no latency, no flow control.
package char_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } char_state_t;

  localparam logic [1:0] CLASS_NONE   = 2'd0;
  localparam logic [1:0] CLASS_MELEE  = 2'd1;
  localparam logic [1:0] CLASS_ARCHER = 2'd2;

  localparam logic [1:0] GAME_MENU = 2'd0;
  localparam logic [1:0] GAME_PLAY = 2'd1;
  localparam logic [1:0] GAME_OVER = 2'd2;

  function automatic logic class_is_valid(input logic [1:0] cls);
    return (cls == CLASS_MELEE) || (cls == CLASS_ARCHER);
  endfunction

  function automatic logic [3:0] aggro_of(input logic [1:0] cls,
                                          input logic [3:0] melee,
                                          input logic [3:0] archer);
    case (cls)
      CLASS_MELEE:  return melee;
      CLASS_ARCHER: return archer;
      default:      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick from vsync rising edge; tick is a registered one-cycle pulse
// one clk after the sampled edge. No backpressure.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      tick    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick    <= vsync & ~vsync_q;
    end
  end

endmodule

// File: rtl/char_ctrl.sv
// Character state controller feeding the sprite drawer; all outputs registered,
// inputs act one cycle later. No backpressure: pulses are consumed when seen.
module char_ctrl
  import char_pkg::*;
#(
  parameter int MAX_HEALTH    = 10,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8,
  parameter int MELEE_AGGRO   = 8,
  parameter int ARCHER_AGGRO  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic [1:0] game_active,
  input  logic [1:0] class_sel,
  input  logic       class_confirm,
  input  logic       hit,
  input  logic [3:0] hit_dmg,
  input  logic       heal,
  input  logic       move_left,
  input  logic       move_right,
  output logic [3:0] current_health,
  output logic [1:0] char_class,
  output logic [3:0] class_aggro,
  output logic       flip_h,
  output logic       blink_hide,
  output logic       died
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0]    MAX_H      = 4'(MAX_HEALTH);
  localparam logic [6:0]    INV_LOAD   = 7'(INVULN_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    AGG_MELEE  = 4'(MELEE_AGGRO);
  localparam logic [3:0]    AGG_ARCHER = 4'(ARCHER_AGGRO);

  char_state_t   state, state_nxt;
  logic [6:0]    inv_cnt, inv_nxt;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic [3:0]    health_nxt, aggro_nxt;
  logic [1:0]    class_nxt;
  logic          flip_nxt, blink_nxt, died_nxt;
  logic          tick;
  logic          hit_ok;
  logic [3:0]    health_inc;
  logic          flip_upd;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .vsync (vsync),
    .tick  (tick)
  );

  assign hit_ok     = hit && (hit_dmg != 4'd0);
  assign health_inc = (current_health >= MAX_H) ? MAX_H : current_health + 4'd1;
  assign flip_upd   = move_left ^ move_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      current_health <= 4'd0;
      char_class     <= CLASS_NONE;
      class_aggro    <= 4'd0;
      flip_h         <= 1'b0;
      blink_hide     <= 1'b0;
      died           <= 1'b0;
      inv_cnt        <= 7'd0;
      blink_cnt      <= '0;
    end else begin
      state          <= state_nxt;
      current_health <= health_nxt;
      char_class     <= class_nxt;
      class_aggro    <= aggro_nxt;
      flip_h         <= flip_nxt;
      blink_hide     <= blink_nxt;
      died           <= died_nxt;
      inv_cnt        <= inv_nxt;
      blink_cnt      <= blink_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    health_nxt    = current_health;
    class_nxt     = char_class;
    inv_nxt       = inv_cnt;
    blink_cnt_nxt = blink_cnt;
    blink_nxt     = blink_hide;
    flip_nxt      = flip_h;
    died_nxt      = 1'b0;

    if (game_active == GAME_OVER) begin
      // Frozen: hold everything; died stays a single-cycle pulse.
    end else if (game_active == GAME_MENU && state != IDLE) begin
      state_nxt     = IDLE;
      class_nxt     = CLASS_NONE;
      health_nxt    = 4'd0;
      inv_nxt       = 7'd0;
      blink_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (class_confirm && class_is_valid(class_sel))
            class_nxt = class_sel;
          if (game_active == GAME_PLAY && char_class != CLASS_NONE) begin
            state_nxt  = ALIVE;
            health_nxt = MAX_H;
          end
        end

        ALIVE: begin
          if (flip_upd)
            flip_nxt = move_left;
          if (hit_ok) begin
            if (current_health <= hit_dmg) begin
              state_nxt  = DEAD;
              health_nxt = 4'd0;
              died_nxt   = 1'b1;
            end else begin
              state_nxt     = INVULN;
              health_nxt    = current_health - hit_dmg;
              inv_nxt       = INV_LOAD;
              blink_cnt_nxt = '0;
              blink_nxt     = 1'b0;
            end
          end else if (heal) begin
            health_nxt = health_inc;
          end
        end

        INVULN: begin
          if (flip_upd)
            flip_nxt = move_left;
          if (heal)
            health_nxt = health_inc;
          if (tick) begin
            if (inv_cnt <= 7'd1) begin
              state_nxt     = ALIVE;
              inv_nxt       = 7'd0;
              blink_cnt_nxt = '0;
            end else begin
              inv_nxt = inv_cnt - 7'd1;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt = '0;
                blink_nxt     = ~blink_hide;
              end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
              end
            end
          end
        end

        DEAD: begin
          health_nxt = 4'd0;
        end

        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt != INVULN)
      blink_nxt = 1'b0;

    aggro_nxt = (state_nxt == DEAD) ? 4'd0 : aggro_of(class_nxt, AGG_MELEE, AGG_ARCHER);
  end

endmodule
